// File: rtl/spi_frame_mailbox.sv
// rtl/spi_frame_mailbox.sv - SPI frame snapshot/validate mailbox with generated reply frame
// Optional CRC-8 integrity check (poly 0x07) when SPI_MAILBOX_CRC8_EN is defined.
module spi_frame_mailbox #(
  parameter logic [7:0] MAGIC_RX = 8'hA5,
  parameter logic [7:0] MAGIC_TX = 8'h5A
) (
  input  logic          sysclock,
  input  logic          sysreset_n,
  input  logic          busy,
  input  logic [2047:0] copi_data,
  output logic [2047:0] cipo_data,
  input  logic [7:0]    rd_addr,
  output logic [7:0]    rd_data,
  input  logic          wr_en,
  input  logic [7:0]    wr_addr,
  input  logic [7:0]    wr_data,
  output logic          frame_ready,
  output logic          frame_valid,
  output logic          frame_error,
  output logic [7:0]    rx_seq,
  output logic [15:0]   err_cnt,
  output logic [15:0]   ovr_cnt
);

  typedef enum logic [1:0] {IDLE, CAPTURE, CHECK, COMMIT} state_t;

  state_t        state_q, state_d;
  logic [7:0]    idx_q, idx_d;
  logic          busy_m_q, busy_m_d, busy_s_q, busy_s_d, busy_p_q, busy_p_d;
  logic [2047:0] snap_q, snap_d;
  logic [2047:0] cipo_q, cipo_d;
  logic [7:0]    rd_data_q, rd_data_d;
  logic          frame_ready_q, frame_ready_d;
  logic          frame_valid_q, frame_valid_d;
  logic          frame_error_q, frame_error_d;
  logic [7:0]    rx_seq_q, rx_seq_d;
  logic [15:0]   err_cnt_q, err_cnt_d;
  logic [15:0]   ovr_cnt_q, ovr_cnt_d;
  logic          ovr_flag_q, ovr_flag_d;
  logic [7:0]    rx_acc_q, rx_acc_d;
  logic [7:0]    tx_acc_q [4];
  logic [7:0]    tx_acc_d [4];
  logic [7:0]    tx_buf_q [256];
  logic [7:0]    tx_buf_d [256];
  logic [7:0]    tx_lat_q [256];
  logic [7:0]    tx_lat_d [256];

  function automatic logic [7:0] acc_byte(input logic [7:0] acc, input logic [7:0] b);
`ifdef SPI_MAILBOX_CRC8_EN
    logic [7:0] c;
    c = acc ^ b;
    for (int k = 0; k < 8; k++)
      c = c[7] ? ({c[6:0], 1'b0} ^ 8'h07) : {c[6:0], 1'b0};
    return c;
`else
    return acc + b;
`endif
  endfunction

  logic       ev;
  logic       rx_ok;
  logic [1:0] sel;
  logic [7:0] gen_byte;
  logic [7:0] rx_byte;
  logic [7:0] tx_fin;

  always_comb begin
    busy_m_d      = busy;
    busy_s_d      = busy_m_q;
    busy_p_d      = busy_s_q;
    state_d       = state_q;
    idx_d         = idx_q;
    snap_d        = snap_q;
    cipo_d        = cipo_q;
    rd_data_d     = snap_q[{rd_addr, 3'b000} +: 8];
    frame_ready_d = frame_ready_q;
    frame_valid_d = 1'b0;
    frame_error_d = 1'b0;
    rx_seq_d      = rx_seq_q;
    err_cnt_d     = err_cnt_q;
    ovr_cnt_d     = ovr_cnt_q;
    ovr_flag_d    = ovr_flag_q;
    rx_acc_d      = rx_acc_q;
    tx_acc_d      = tx_acc_q;
    tx_buf_d      = tx_buf_q;
    tx_lat_d      = tx_lat_q;

    ev      = busy_p_q & ~busy_s_q;
    rx_byte = snap_q[{idx_q, 3'b000} +: 8];
`ifdef SPI_MAILBOX_CRC8_EN
    rx_ok = (snap_q[7:0] == MAGIC_RX) && (rx_acc_q == snap_q[2047:2040]);
`else
    rx_ok = (snap_q[7:0] == MAGIC_RX) && (rx_acc_q == 8'h00);
`endif
    sel    = {rx_ok, ovr_flag_q};
    tx_fin = tx_acc_q[sel];

    if (idx_q == 8'd0)      gen_byte = MAGIC_TX;
    else if (idx_q == 8'd1) gen_byte = snap_q[15:8];
    else                    gen_byte = tx_buf_q[idx_q];

    if (wr_en && wr_addr != 8'd0 && wr_addr != 8'd1 && wr_addr != 8'd2 && wr_addr != 8'd255)
      tx_buf_d[wr_addr] = wr_data;

    // A falling busy while busy processing a frame means that exchange is lost.
    if (ev && state_q != IDLE) begin
      ovr_flag_d = 1'b1;
      if (ovr_cnt_q != 16'hFFFF) ovr_cnt_d = ovr_cnt_q + 16'd1;
    end

    case (state_q)
      IDLE: if (ev) state_d = CAPTURE;
      CAPTURE: begin
        snap_d        = copi_data;
        frame_ready_d = 1'b0;
        rx_acc_d      = 8'h00;
        for (int v = 0; v < 4; v++) tx_acc_d[v] = 8'h00;
        idx_d         = 8'd0;
        state_d       = CHECK;
      end
      CHECK: begin
`ifdef SPI_MAILBOX_CRC8_EN
        if (idx_q != 8'd255) rx_acc_d = acc_byte(rx_acc_q, rx_byte);
`else
        rx_acc_d = acc_byte(rx_acc_q, rx_byte);
`endif
        // Byte 2 is not known until commit, so track one checksum per possible value.
        if (idx_q != 8'd255) begin
          for (int v = 0; v < 4; v++)
            tx_acc_d[v] = acc_byte(tx_acc_q[v], (idx_q == 8'd2) ? {2'(v), 6'b0} : gen_byte);
        end
        tx_lat_d[idx_q] = tx_buf_q[idx_q];
        idx_d = idx_q + 8'd1;
        if (idx_q == 8'd255) state_d = COMMIT;
      end
      COMMIT: begin
        if (!busy_s_q) begin
          cipo_d[7:0]   = MAGIC_TX;
          cipo_d[15:8]  = snap_q[15:8];
          cipo_d[23:16] = {sel, 6'b0};
          for (int k = 3; k < 255; k++) cipo_d[8*k +: 8] = tx_lat_q[k];
`ifdef SPI_MAILBOX_CRC8_EN
          cipo_d[2047:2040] = tx_fin;
`else
          cipo_d[2047:2040] = 8'h00 - tx_fin;
`endif
          if (ovr_flag_q && !(ev)) ovr_flag_d = 1'b0;
          if (rx_ok) begin
            frame_valid_d = 1'b1;
            frame_ready_d = 1'b1;
            rx_seq_d      = snap_q[15:8];
          end else begin
            frame_error_d = 1'b1;
            if (err_cnt_q != 16'hFFFF) err_cnt_d = err_cnt_q + 16'd1;
          end
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge sysclock or negedge sysreset_n) begin
    if (!sysreset_n) begin
      state_q       <= IDLE;
      idx_q         <= 8'd0;
      busy_m_q      <= 1'b0;
      busy_s_q      <= 1'b0;
      busy_p_q      <= 1'b0;
      snap_q        <= '0;
      cipo_q        <= '0;
      rd_data_q     <= 8'h00;
      frame_ready_q <= 1'b0;
      frame_valid_q <= 1'b0;
      frame_error_q <= 1'b0;
      rx_seq_q      <= 8'h00;
      err_cnt_q     <= 16'h0000;
      ovr_cnt_q     <= 16'h0000;
      ovr_flag_q    <= 1'b0;
      rx_acc_q      <= 8'h00;
      for (int v = 0; v < 4; v++) tx_acc_q[v] <= 8'h00;
      for (int k = 0; k < 256; k++) begin
        tx_buf_q[k] <= 8'h00;
        tx_lat_q[k] <= 8'h00;
      end
    end else begin
      state_q       <= state_d;
      idx_q         <= idx_d;
      busy_m_q      <= busy_m_d;
      busy_s_q      <= busy_s_d;
      busy_p_q      <= busy_p_d;
      snap_q        <= snap_d;
      cipo_q        <= cipo_d;
      rd_data_q     <= rd_data_d;
      frame_ready_q <= frame_ready_d;
      frame_valid_q <= frame_valid_d;
      frame_error_q <= frame_error_d;
      rx_seq_q      <= rx_seq_d;
      err_cnt_q     <= err_cnt_d;
      ovr_cnt_q     <= ovr_cnt_d;
      ovr_flag_q    <= ovr_flag_d;
      rx_acc_q      <= rx_acc_d;
      tx_acc_q      <= tx_acc_d;
      tx_buf_q      <= tx_buf_d;
      tx_lat_q      <= tx_lat_d;
    end
  end

  assign cipo_data   = cipo_q;
  assign rd_data     = rd_data_q;
  assign frame_ready = frame_ready_q;
  assign frame_valid = frame_valid_q;
  assign frame_error = frame_error_q;
  assign rx_seq      = rx_seq_q;
  assign err_cnt     = err_cnt_q;
  assign ovr_cnt     = ovr_cnt_q;

endmodule
